reg_slave_responder: RTL

- Register-side responder for the packet divider/reorder design's 8-bit register bus.
- Decodes the addr/wr/wr_data/rd bus driven by the host-side register agent and returns rd_data.
- Buffers received packet bytes in an RX FIFO and drives the active-low int_n when RX data is available.
- Provides a single-byte TX holding register with a valid/ready handshake toward the packet path.

---
 rtl/reg_slave_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/reg_slave_responder.sv
// Register-bus responder: CTRL/STATUS/SCRATCH/ID registers, an RX byte FIFO
// with an active-low interrupt, and a single-byte TX holding register.
module reg_slave_responder #(
  parameter int unsigned RX_DEPTH = 16,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] addr,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       int_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          en, int_en, ovf, tx_drop;
  logic [7:0]    scratch;

  logic          rd_eff, flush, pop, full, push, ovf_set;
  logic          tx_wr, tx_hs, tx_drop_set, tx_load;
  logic          en_nxt, int_en_nxt;
  logic [7:0]    rd_mux;

  always_comb begin
    rd_eff      = rd & ~wr;
    full        = (count == CW'(RX_DEPTH));
    flush       = wr && (addr == 3'd0) && wr_data[2];
    pop         = rd_eff && (addr == 3'd3) && (count != '0);
    // A pop frees a slot in the same cycle, so a push while full still lands.
    push        = rx_valid && en && !flush && (!full || pop);
    ovf_set     = rx_valid && en && !flush && full && !pop;
    tx_wr       = wr && (addr == 3'd4);
    tx_hs       = tx_valid && tx_ready;
    tx_load     = tx_wr && (!tx_valid || tx_hs);
    tx_drop_set = tx_wr && tx_valid && !tx_ready;
    en_nxt      = en;
    int_en_nxt  = int_en;
    if (wr && (addr == 3'd0)) begin
      en_nxt     = wr_data[0];
      int_en_nxt = wr_data[1];
    end
    if (flush) count_nxt = '0;
    else       count_nxt = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      3'd0: rd_mux = {6'b0, int_en, en};
      3'd1: rd_mux = {3'b0, tx_drop, tx_valid, ovf, full, (count != '0)};
      3'd2: rd_mux = 8'(count);
      3'd3: rd_mux = (count != '0) ? mem[rd_ptr] : '0;
      3'd5: rd_mux = scratch;
      3'd6: rd_mux = ID_VALUE;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      en       <= 1'b0;
      int_en   <= 1'b0;
      ovf      <= 1'b0;
      tx_drop  <= 1'b0;
      scratch  <= '0;
      rd_data  <= '0;
      int_n    <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count  <= count_nxt;
      en     <= en_nxt;
      int_en <= int_en_nxt;
      int_n  <= ~(int_en_nxt & (count_nxt != '0));

      // Set takes priority over write-1-to-clear.
      if (ovf_set)                                 ovf <= 1'b1;
      else if (wr && (addr == 3'd1) && wr_data[2]) ovf <= 1'b0;
      if (tx_drop_set)                             tx_drop <= 1'b1;
      else if (wr && (addr == 3'd1) && wr_data[4]) tx_drop <= 1'b0;

      if (wr && (addr == 3'd5)) scratch <= wr_data;
      if (rd_eff) rd_data <= rd_mux;

      if (tx_load) begin
        tx_data  <= wr_data;
        tx_valid <= 1'b1;
      end else if (tx_hs) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule
